// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: unsigned a*b over WIDTH cycles.
// Handshake is start (sampled in IDLE) and a one-cycle done pulse; the
// state code is exported on st_out for the debug display.
// Optional build macro: EARLY_TERM_EN -- finish CALC as soon as the
// remaining multiplier bits are all zero (results are unchanged).
module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [3:0]           st_out
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q,     acc_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [3:0]      st_out_q,  st_out_d;

    // One CALC iteration: conditional add and the shifted multiplier.
    logic [PW-1:0]    acc_sum;
    logic [WIDTH-1:0] mplier_sh;
    logic             calc_last;

    // Datapath arithmetic for the current CALC iteration.
    always_comb begin
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
        mplier_sh = mplier_q >> 1;
`ifdef EARLY_TERM_EN
        calc_last = (cnt_q == CNT_LAST) || (mplier_sh == WIDTH'(0));
`else
        calc_last = (cnt_q == CNT_LAST);
`endif
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                acc_d   = PW'(0);
                cnt_d   = CW'(0);
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + CW'(1);
                if (calc_last) begin
                    product_d = acc_sum;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the state being entered, so they are flops.
    always_comb begin
        busy_d   = (state_d == ST_LOAD) || (state_d == ST_CALC);
        done_d   = (state_d == ST_DONE);
        st_out_d = {2'b00, state_d};
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            st_out_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            st_out_q  <= st_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign st_out  = st_out_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Randomized self-checking bench for seq_shift_add_mult against a
// plain-arithmetic reference (product = a*b, latency from operand bits).
module tb_seq_shift_add_mult;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PW    = 2 * WIDTH;
`ifdef EARLY_TERM_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [PW-1:0]    product;
    logic [3:0]       st_out;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [PW-1:0]    last_prod;

    seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .st_out  (st_out)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Cycles from the start edge until done is visible.
    function automatic int ref_latency(input logic [WIDTH-1:0] bv);
        int hi = 1;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) hi = i + 1;
        return EARLY_EN ? hi + 2 : int'(WIDTH) + 2;
    endfunction

    // One operation from a negedge; optional stray starts while busy / in DONE.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input bit inj_busy, input bit inj_done);
        int            lat;
        logic [PW-1:0] exp_p;
        lat   = ref_latency(bv);
        exp_p = PW'(av) * PW'(bv);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            if (k < lat) begin
                chk_eq("st_busy", int'(st_out), (k == 1) ? 1 : 2);
                chk_eq("busy", int'(busy), 1);
                chk_eq("done_early", int'(done), 0);
                chk_eq("prod_held", int'(product), int'(last_prod));
            end else begin
                chk_eq("st_done", int'(st_out), 3);
                chk_eq("busy_done", int'(busy), 0);
                chk_eq("done", int'(done), 1);
                chk_eq("product", int'(product), int'(exp_p));
            end
            if (k == 2) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                if (inj_busy) begin a = 4'd2; b = 4'd2; start = 1'b1; end
            end
            if (k == 3) start = 1'b0;
        end
        last_prod = exp_p;
        if (inj_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("st_idle", int'(st_out), 0);
        chk_eq("done_pulse", int'(done), 0);
        chk_eq("busy_idle", int'(busy), 0);
        chk_eq("prod_after", int'(product), int'(exp_p));
        if (inj_busy || inj_done) begin
            repeat (8) begin
                @(negedge clk);
                chk_eq("no_extra_done", int'(done), 0);
                chk_eq("stay_idle", int'(st_out), 0);
                chk_eq("prod_kept", int'(product), int'(exp_p));
            end
        end
    endtask

    // start held high; operands change right after each done.
    task automatic run_b2b();
        logic [WIDTH-1:0] pa [6];
        logic [WIDTH-1:0] pb [6];
        int               idx  = 0;
        int               prev = 0;
        int               cyc  = 0;
        for (int i = 0; i < 6; i++) begin
            pa[i] = WIDTH'($urandom);
            pb[i] = WIDTH'($urandom);
        end
        a = pa[0]; b = pb[0]; start = 1'b1;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk_eq("b2b_product", int'(product), int'(PW'(pa[idx]) * PW'(pb[idx])));
                if (idx == 0) chk_eq("b2b_first_lat", cyc, ref_latency(pb[0]));
                else chk_eq("b2b_spacing", cyc - prev, ref_latency(pb[idx]) + 1);
                last_prod = PW'(pa[idx]) * PW'(pb[idx]);
                prev = cyc;
                idx++;
                if (idx < 6) begin a = pa[idx]; b = pb[idx]; end
            end
        end
        start = 1'b0;
        chk_eq("b2b_count", idx, 6);
        @(negedge clk);
        chk_eq("b2b_idle", int'(st_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; last_prod = '0;
        #12;
        chk_eq("rst_st", int'(st_out), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_prod", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("idle_st", int'(st_out), 0);

        run_op(4'd3,  4'd5,  1'b0, 1'b0);
        run_op(4'd15, 4'd15, 1'b0, 1'b0);
        run_op(4'd0,  4'd9,  1'b0, 1'b0);
        run_op(4'd7,  4'd6,  1'b1, 1'b0);
        run_op(4'd5,  4'd5,  1'b0, 1'b1);

        // Asynchronous reset two cycles into an operation.
        a = 4'd9; b = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_st", int'(st_out), 0);
        chk_eq("arst_busy", int'(busy), 0);
        chk_eq("arst_done", int'(done), 0);
        chk_eq("arst_prod", int'(product), 0);
        repeat (3) begin
            @(negedge clk);
            chk_eq("arst_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        last_prod = '0;
        @(negedge clk);
        run_op(4'd9, 4'd11, 1'b0, 1'b0);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                run_op(WIDTH'(ia), WIDTH'(ib), 1'b0, 1'b0);

        repeat (40) run_op(WIDTH'($urandom), WIDTH'($urandom),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        run_b2b();

        run_op(4'd13, 4'd1, 1'b0, 1'b0);
        run_op(4'd13, 4'd8, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Sequential shift-and-add multiplier that produces the 8-bit product the top-level datapath writes into the result RAM.
- Sits between the operand-ROM read stage, which supplies a and b, and the RAM write stage, which consumes product on done.
- One-bit start/done handshake; the state code is exported for the st_out debug display.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; latched on accepted start.
- b  input  WIDTH  multiplier; latched on accepted start.
- busy  output  1  high in LOAD and CALC.
- done  output  1  one-cycle pulse, high in DONE.
- product  output  2*WIDTH  last result; held until the next DONE.
- st_out  output  4  state code: IDLE=0, LOAD=1, CALC=2, DONE=3.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, product=0, st_out=0. Internal mcand/mplier/acc/cnt are cleared.
- Reset mid-operation aborts the operation. No done is issued. product returns to 0.
- IDLE: on an edge with start=1, latch mcand={WIDTH zeros,a} and mplier=b, then go to LOAD. With start=0, stay in IDLE.
- LOAD: acc=0, cnt=0. Go to CALC unconditionally (1 cycle).
- CALC, one iteration per edge:
  - If mplier[0]=1, acc=acc+mcand, computed in 2*WIDTH bits with no overflow possible.
  - mcand shifts left 1; mplier shifts right 1 (logical); cnt increments.
  - On the edge where cnt==WIDTH-1, go to DONE and load product with the final acc, including this iteration's add.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. A start present during DONE is ignored; it is sampled only once back in IDLE.
- Latency: start sampled at edge E0 gives done high during the cycle following edge E0+WIDTH+1. For WIDTH=4, done is asserted 6 cycles after the start edge.
- Throughput: next start accepted at the first edge in IDLE. Minimum start-to-start spacing is WIDTH+3 cycles.
- start while busy or in DONE is ignored; a and b changing during an operation have no effect.
- start held high continuously produces back-to-back operations: each IDLE edge accepts a new operand pair.
- Outputs busy, done and st_out are decoded from the registered state only (no input-to-output combinational path).
- product changes only on entry to DONE (and on reset).
- Result: product = a*b, unsigned, exact for all 2^(2*WIDTH) operand pairs.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined:
  - In CALC, also go to DONE on any edge where the post-shift mplier is zero, loading product with that edge's acc.
  - b=0 or b=1 completes after one CALC edge, so done appears 3 cycles after the start edge.
  - b with highest set bit k completes after k+1 CALC edges.
  - Results are identical to the non-macro build.
- Not defined: fixed WIDTH CALC cycles regardless of operand values; the latency above holds exactly.

Test Plan:
- Reset, then start=1 for one cycle with a=3, b=5 -> busy=1 for 5 cycles, st_out sequence 1,2,2,2,2,3; done=1 for one cycle 6 cycles after start; product=15 held until next done.
- a=15, b=15 -> product=225; then a=0, b=9 -> product=0; exhaustive loop over all 256 pairs against a reference multiply, each result checked on done.
- start=1 with a=7, b=6; while busy, pulse start with a=2, b=2 -> only one done; product=42; the second request is not executed.
- start with a=9, b=11; assert rst=0 two cycles later -> st_out=0, busy=0, product=0 immediately (asynchronous); no done; after release, a=9, b=11 -> product=99.
- start held high continuously, with a and b changed after each done -> successive products correct, done pulses spaced 7 cycles apart.
- EARLY_TERM_EN build: a=13, b=1 -> product=13, done 3 cycles after start; a=13, b=8 -> product=104, done 6 cycles after start.
